// File: rtl/interrupt_ctrl_pkg.sv
// Register map and reset constants shared by the interrupt controller and its bench.
package interrupt_ctrl_pkg;

    localparam logic [7:0] REG_MSIP        = 8'h00;
    localparam logic [7:0] REG_PENDING     = 8'h04;
    localparam logic [7:0] REG_ENABLE      = 8'h08;
    localparam logic [7:0] REG_MODE        = 8'h0C;
    localparam logic [7:0] REG_SET         = 8'h10;
    localparam logic [7:0] REG_MTIME_LO    = 8'h18;
    localparam logic [7:0] REG_MTIME_HI    = 8'h1C;
    localparam logic [7:0] REG_MTIMECMP_LO = 8'h20;
    localparam logic [7:0] REG_MTIMECMP_HI = 8'h24;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        return (old_val & ~sel_mask(sel)) | (new_val & sel_mask(sel));
    endfunction

endpackage

// File: rtl/interrupt_ctrl_irq_source.sv
// One external interrupt source: 2-flop synchroniser, rising-edge detector and pending state.
// Latency: level pending follows src after 2 edges; an edge sets pending on the 3rd edge.
// Backpressure: none; w1c/set are single-cycle strobes, set wins over a coincident clear.
module irq_source
    import interrupt_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    input  logic w1c,
    input  logic set,
    output logic pending
);

    logic s1, s2, s3;
    logic edge_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            edge_pend <= 1'b0;
        end else begin
            s1 <= src;
            s2 <= s1;
            s3 <= s2;
            // Level sources keep the edge state clear so a later mode switch starts clean.
            if (!mode)
                edge_pend <= 1'b0;
            else
                edge_pend <= (edge_pend & ~w1c) | (s2 & ~s3) | set;
        end
    end

    assign pending = mode ? edge_pend : s2;

endmodule

// File: rtl/interrupt_ctrl.sv
// Wishbone interrupt controller: N external sources, MSIP and a prescaled 64-bit mtime/mtimecmp timer.
// Latency: bus response 1 cycle; level source to external_interrupt 3 edges, edge source 4 edges.
// Backpressure: one outstanding access; ack/err pulse for one cycle, a held strobe is answered every other cycle.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int          NSOURCES  = 4,
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         int_addr,
    input  logic [31:0]         int_dat_w,
    input  logic [3:0]          int_sel,
    input  logic                int_cyc,
    input  logic                int_stb,
    input  logic [2:0]          int_cti,
    input  logic [1:0]          int_bte,
    input  logic                int_we,
    output logic [31:0]         int_dat_r,
    output logic                int_ack,
    output logic                int_err,
    input  logic [NSOURCES-1:0] ext_src,
    output logic                external_interrupt,
    output logic                timer_interrupt,
    output logic                software_interrupt
);

    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [7:0]          off;
    logic                req;
    logic                mapped;
    logic                wr;
    logic [31:0]         rdata;
    logic [31:0]         wbits;
    logic                msip;
    logic [NSOURCES-1:0] enable_q;
    logic [NSOURCES-1:0] mode_q;
    logic [NSOURCES-1:0] pending;
    logic [NSOURCES-1:0] w1c_vec;
    logic [NSOURCES-1:0] set_vec;
    logic [63:0]         mtime;
    logic [63:0]         mtimecmp;
    logic [PW-1:0]       presc;
    logic                tick;
    logic                unused_bits;

    // The window is decoded on the low byte only; the base is resolved upstream.
    assign off         = {int_addr[7:2], 2'b00};
    assign unused_bits = ^{int_addr[31:8], int_addr[1:0], int_cti, int_bte, BASE_ADDR};

    assign req   = int_cyc & int_stb & ~int_ack & ~int_err;
    assign wr    = req & mapped & int_we;
    assign wbits = int_dat_w & sel_mask(int_sel);

    assign w1c_vec = (wr && off == REG_PENDING) ? NSOURCES'(wbits) : '0;
    assign set_vec = (wr && off == REG_SET)     ? NSOURCES'(wbits) : '0;

    always_comb begin
        mapped = 1'b1;
        rdata  = '0;
        case (off)
            REG_MSIP:        rdata = {31'd0, msip};
            REG_PENDING:     rdata = 32'(pending);
            REG_ENABLE:      rdata = 32'(enable_q);
            REG_MODE:        rdata = 32'(mode_q);
            REG_SET:         rdata = '0;
            REG_MTIME_LO:    rdata = mtime[31:0];
            REG_MTIME_HI:    rdata = mtime[63:32];
            REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
            default:         mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_ack   <= 1'b0;
            int_err   <= 1'b0;
            int_dat_r <= '0;
        end else begin
            int_ack   <= req & mapped;
            int_err   <= req & ~mapped;
            int_dat_r <= (req && mapped && !int_we) ? rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip     <= 1'b0;
            enable_q <= '0;
            mode_q   <= '0;
            mtimecmp <= MTIMECMP_RST;
        end else if (wr) begin
            case (off)
                REG_MSIP:        if (int_sel[0]) msip <= int_dat_w[0];
                REG_ENABLE:      enable_q <= NSOURCES'(byte_merge(32'(enable_q), int_dat_w, int_sel));
                REG_MODE:        mode_q   <= NSOURCES'(byte_merge(32'(mode_q), int_dat_w, int_sel));
                REG_MTIMECMP_LO: mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], int_dat_w, int_sel);
                REG_MTIMECMP_HI: mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], int_dat_w, int_sel);
                default: ;
            endcase
        end
    end

    assign tick = (presc == PRESC_MAX);

    // A software write to either mtime half replaces that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (wr && off == REG_MTIME_LO)
                mtime[31:0] <= byte_merge(mtime[31:0], int_dat_w, int_sel);
            else if (wr && off == REG_MTIME_HI)
                mtime[63:32] <= byte_merge(mtime[63:32], int_dat_w, int_sel);
            else if (tick)
                mtime <= mtime + 64'd1;
        end
    end

    for (genvar i = 0; i < NSOURCES; i++) begin : g_src
        irq_source u_src (
            .clk     (clk),
            .rst     (rst),
            .src     (ext_src[i]),
            .mode    (mode_q[i]),
            .w1c     (w1c_vec[i]),
            .set     (set_vec[i]),
            .pending (pending[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            external_interrupt <= 1'b0;
            timer_interrupt    <= 1'b0;
        end else begin
            external_interrupt <= |(pending & enable_q);
            timer_interrupt    <= (mtime >= mtimecmp);
        end
    end

    assign software_interrupt = msip;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: register table plus hand-written latency and timer sequences.
module tb_interrupt_ctrl;
    import interrupt_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] int_addr;
    logic [31:0] int_dat_w;
    logic [3:0]  int_sel;
    logic        int_cyc;
    logic        int_stb;
    logic [2:0]  int_cti;
    logic [1:0]  int_bte;
    logic        int_we;
    logic [31:0] int_dat_r;
    logic        int_ack;
    logic        int_err;
    logic [3:0]  ext_src;
    logic        external_interrupt;
    logic        timer_interrupt;
    logic        software_interrupt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interrupt_ctrl #(.NSOURCES(4), .PRESCALE(4), .BASE_ADDR(BASE)) dut (
        .clk                (clk),
        .rst                (rst),
        .int_addr           (int_addr),
        .int_dat_w          (int_dat_w),
        .int_sel            (int_sel),
        .int_cyc            (int_cyc),
        .int_stb            (int_stb),
        .int_cti            (int_cti),
        .int_bte            (int_bte),
        .int_we             (int_we),
        .int_dat_r          (int_dat_r),
        .int_ack            (int_ack),
        .int_err            (int_err),
        .ext_src            (ext_src),
        .external_interrupt (external_interrupt),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Starts at a falling edge, returns at the falling edge after the response.
    task automatic bus(input logic we, input logic [7:0] off, input logic [31:0] wd,
                       input logic [3:0] sel, output logic [31:0] rd,
                       output logic got_ack, output logic got_err);
        int_addr  = BASE | {24'h0, off};
        int_we    = we;
        int_dat_w = wd;
        int_sel   = sel;
        int_cyc   = 1'b1;
        int_stb   = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (int_ack || int_err) break;
        end
        got_ack = int_ack;
        got_err = int_err;
        rd      = int_dat_r;
        int_cyc = 1'b0;
        int_stb = 1'b0;
        int_we  = 1'b0;
        if (!(got_ack || got_err)) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout off=%0h: got no response expected ack or err", off);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        logic        a, e;
        bus(1'b1, off, d, sel, r, a, e);
        check($sformatf("wr_ack_%0h", off), 64'(a), 64'd1);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r;
        logic        a, e;
        bus(1'b0, off, 32'h0, 4'hF, r, a, e);
        check({name, "_ack"}, 64'(a), 64'd1);
        check(name, 64'(r), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        a, e;
        int          n;

        tbl[0]  = '{1'b0, REG_MSIP,        32'h0,        4'hF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, REG_PENDING,     32'h0,        4'hF, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, REG_ENABLE,      32'h0,        4'hF, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, REG_MODE,        32'h0,        4'hF, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, REG_SET,         32'h0,        4'hF, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, REG_MTIME_HI,    32'h0,        4'hF, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, REG_MTIMECMP_LO, 32'h0,        4'hF, 1'b0, 32'hFFFF_FFFF};
        tbl[7]  = '{1'b0, REG_MTIMECMP_HI, 32'h0,        4'hF, 1'b0, 32'hFFFF_FFFF};
        tbl[8]  = '{1'b0, 8'h14,           32'h0,        4'hF, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 8'h28,           32'h0,        4'hF, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 8'hFC,           32'h0,        4'hF, 1'b1, 32'h0};
        tbl[11] = '{1'b1, REG_ENABLE,      32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        tbl[12] = '{1'b0, REG_ENABLE,      32'h0,        4'hF, 1'b0, 32'h0000_000F};
        tbl[13] = '{1'b1, REG_ENABLE,      32'h1234_5670, 4'h1, 1'b0, 32'h0};
        tbl[14] = '{1'b0, REG_ENABLE,      32'h0,        4'hF, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 8'h14,           32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        tbl[16] = '{1'b1, REG_MODE,        32'h0000_000A, 4'hF, 1'b0, 32'h0};
        tbl[17] = '{1'b0, REG_MODE,        32'h0,        4'hF, 1'b0, 32'h0000_000A};
        tbl[18] = '{1'b1, REG_MODE,        32'h0,        4'hF, 1'b0, 32'h0};

        rst = 1'b1;
        int_addr = '0; int_dat_w = '0; int_sel = '0; int_cyc = 1'b0; int_stb = 1'b0;
        int_cti = '0; int_bte = '0; int_we = 1'b0; ext_src = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(int_ack), 64'd0);
        check("rst_dat_r", 64'(int_dat_r), 64'd0);
        rst = 1'b0;
        cyc_wait(1);
        check("rst_ext_irq", 64'(external_interrupt), 64'd0);
        check("rst_tmr_irq", 64'(timer_interrupt), 64'd0);
        check("rst_sw_irq", 64'(software_interrupt), 64'd0);

        foreach (tbl[i]) begin
            bus(tbl[i].we, tbl[i].off, tbl[i].wd, tbl[i].sel, r, a, e);
            check($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
            check($sformatf("tbl%0d_ack", i), 64'(a), 64'(!tbl[i].exp_err));
            if (!tbl[i].we && !tbl[i].exp_err)
                check($sformatf("tbl%0d_dat", i), 64'(r), 64'(tbl[i].exp_dat));
        end

        // Level source 0: 3-edge latency both ways, W1C has no effect.
        wr(REG_ENABLE, 32'h1, 4'hF);
        ext_src[0] = 1'b1;
        cyc_wait(2);
        check("lvl_rise_2edges", 64'(external_interrupt), 64'd0);
        cyc_wait(1);
        check("lvl_rise_3edges", 64'(external_interrupt), 64'd1);
        wr(REG_PENDING, 32'h1, 4'hF);
        rd_chk("lvl_w1c_ignored", REG_PENDING, 32'h1);
        check("lvl_irq_after_w1c", 64'(external_interrupt), 64'd1);
        ext_src[0] = 1'b0;
        cyc_wait(2);
        check("lvl_fall_2edges", 64'(external_interrupt), 64'd1);
        cyc_wait(1);
        check("lvl_fall_3edges", 64'(external_interrupt), 64'd0);

        // Edge source 1: one-cycle pulse latches, W1C clears, coincident edge wins.
        wr(REG_MODE, 32'h2, 4'hF);
        wr(REG_ENABLE, 32'h2, 4'hF);
        cyc_wait(2);
        ext_src[1] = 1'b1;
        cyc_wait(1);
        ext_src[1] = 1'b0;
        cyc_wait(2);
        check("edge_3edges", 64'(external_interrupt), 64'd0);
        cyc_wait(1);
        check("edge_4edges", 64'(external_interrupt), 64'd1);
        cyc_wait(3);
        check("edge_held", 64'(external_interrupt), 64'd1);
        rd_chk("edge_pending", REG_PENDING, 32'h2);
        wr(REG_PENDING, 32'h2, 4'hF);
        check("edge_w1c_same_cycle", 64'(external_interrupt), 64'd1);
        cyc_wait(1);
        check("edge_w1c_next_cycle", 64'(external_interrupt), 64'd0);
        rd_chk("edge_cleared", REG_PENDING, 32'h0);
        ext_src[1] = 1'b1;
        cyc_wait(1);
        ext_src[1] = 1'b0;
        cyc_wait(1);
        wr(REG_PENDING, 32'h2, 4'hF);
        rd_chk("edge_vs_w1c", REG_PENDING, 32'h2);
        wr(REG_PENDING, 32'h2, 4'hF);
        rd_chk("edge_recleared", REG_PENDING, 32'h0);

        // Software SET on edge source 2; SET on level source 0 ignored.
        wr(REG_MODE, 32'h4, 4'hF);
        wr(REG_ENABLE, 32'h0, 4'hF);
        wr(REG_SET, 32'h5, 4'hF);
        rd_chk("set_pending", REG_PENDING, 32'h4);
        rd_chk("set_reads_zero", REG_SET, 32'h0);
        check("set_disabled_irq", 64'(external_interrupt), 64'd0);
        wr(REG_ENABLE, 32'h4, 4'hF);
        check("enable_same_cycle", 64'(external_interrupt), 64'd0);
        cyc_wait(1);
        check("enable_next_cycle", 64'(external_interrupt), 64'd1);
        wr(REG_PENDING, 32'h4, 4'hF);
        cyc_wait(1);
        check("set_w1c_irq", 64'(external_interrupt), 64'd0);

        // Timer: mtimecmp = 10 with PRESCALE 4.
        wr(REG_MTIMECMP_LO, 32'd10, 4'hF);
        wr(REG_MTIMECMP_HI, 32'd0, 4'hF);
        wr(REG_MTIME_HI, 32'd0, 4'hF);
        wr(REG_MTIME_LO, 32'd0, 4'hF);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc_wait(1);
            if (timer_interrupt) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n < 38 || n > 41) begin
            errors++;
            $display("FAIL timer_rise_cycles: got %0d expected 38..41", n);
        end
        rd_chk("timer_mtime_lo", REG_MTIME_LO, 32'd10);
        wr(REG_MTIMECMP_LO, 32'hFFFF_FFFF, 4'hF);
        check("timer_hold_at_write", 64'(timer_interrupt), 64'd1);
        cyc_wait(1);
        check("timer_fall", 64'(timer_interrupt), 64'd0);

        // MSIP and byte lanes.
        wr(REG_MSIP, 32'h1, 4'b0001);
        check("msip_set", 64'(software_interrupt), 64'd1);
        wr(REG_MSIP, 32'h0, 4'b1110);
        check("msip_lane_masked", 64'(software_interrupt), 64'd1);
        rd_chk("msip_read", REG_MSIP, 32'h1);
        wr(REG_MSIP, 32'h0, 4'b0001);
        check("msip_clear", 64'(software_interrupt), 64'd0);
        wr(REG_MTIME_HI, 32'hAABB_CCDD, 4'b0010);
        rd_chk("mtime_hi_byte1", REG_MTIME_HI, 32'h0000_CC00);

        // Held strobe: one response every other cycle.
        cyc_wait(1);
        int_addr = BASE | {24'h0, REG_ENABLE};
        int_we   = 1'b0;
        int_cyc  = 1'b1;
        int_stb  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc_wait(1);
            check($sformatf("held_ack_%0d", i), 64'(int_ack), 64'(i % 2 == 0));
        end
        int_cyc = 1'b0;
        int_stb = 1'b0;

        // Reset in the middle of an acknowledged access.
        cyc_wait(1);
        int_addr = BASE | {24'h0, REG_MTIME_LO};
        int_cyc  = 1'b1;
        int_stb  = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ack_before", 64'(int_ack), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ack_dropped", 64'(int_ack), 64'd0);
        int_cyc = 1'b0;
        int_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc_wait(1);
        check("mid_rst_ext_irq", 64'(external_interrupt), 64'd0);
        check("mid_rst_sw_irq", 64'(software_interrupt), 64'd0);
        rd_chk("mid_rst_enable", REG_ENABLE, 32'h0);
        rd_chk("mid_rst_mtimecmp_hi", REG_MTIMECMP_HI, 32'hFFFF_FFFF);
        cyc_wait(1);
        check("dat_r_idle_zero", 64'(int_dat_r), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
